// File: rtl/fifo_reader.sv
// fifo_reader: paces read strobes to an edge-detecting FIFO, one word in
// flight, and presents each word downstream over a valid/ready handshake.
module fifo_reader #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int FRAME_WORDS = 76800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        d_available,
    input  logic [15:0] r_data,
    output logic        r_en,
    output logic [15:0] out_data,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] word_count,
    output logic        frame_done
);
    localparam int MAX_PH = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_PH + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [16:0] LAST_WORD   = 17'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        STROBE_HI,
        STROBE_LO,
        CAPTURE,
        PRESENT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ph_q, ph_d;
    logic          r_en_q, r_en_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [16:0]   wc_q, wc_d;
    logic          fd_q, fd_d;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        wc_d        = wc_q;
        fd_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && d_available) begin
                    state_d = STROBE_HI;
                    ph_d    = '0;
                end
            end
            STROBE_HI: begin
                if (ph_q == HOLD_LAST) begin
                    state_d = STROBE_LO;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            STROBE_LO: begin
                if (ph_q == GAP_LAST) begin
                    state_d = CAPTURE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            CAPTURE: begin
                out_data_d  = r_data;
                out_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (wc_q == LAST_WORD) begin
                        wc_d = '0;
                        fd_d = 1'b1;
                    end else begin
                        wc_d = wc_q + 17'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered from the next state so r_en is high exactly in STROBE_HI.
        r_en_d = (state_d == STROBE_HI);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            r_en_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wc_q        <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            r_en_q      <= r_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            wc_q        <= wc_d;
            fd_q        <= fd_d;
        end
    end

    assign r_en       = r_en_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign word_count = wc_q;
    assign frame_done = fd_q;
    assign out_r      = {out_data_q[15:11], out_data_q[15:13]};
    assign out_g      = {out_data_q[10:5], out_data_q[10:9]};
    assign out_b      = {out_data_q[4:0], out_data_q[4:2]};
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model with edge-detected pops, scoreboard of
// expected words, and directed steps for pacing, backpressure, frames, reset.
module tb_fifo_reader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        d_available = 1'b0;
    logic [15:0] r_data = 16'h0;
    logic        r_en;
    logic [15:0] out_data;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] word_count;
    logic        frame_done;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          m_wc = 0;
    logic        m_fd = 1'b0;
    logic        inflight = 1'b0;
    int          strobes = 0;
    int          fd_pulses = 0;
    logic        ren_prev = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [15:0] sb_e;
    logic [23:0] sb_rgb;

    fifo_reader #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (4),
        .FRAME_WORDS(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .d_available(d_available),
        .r_data     (r_data),
        .r_en       (r_en),
        .out_data   (out_data),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rgb888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // FIFO model and scoreboard, one process
    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_wc = 0;
            m_fd = 1'b0;
            if (inflight) begin
                exp_q.delete(0);
                inflight = 1'b0;
            end
        end
        if (r_en && !ren_prev) begin
            strobes++;
            if (fifo_q.size() > 0) begin
                r_data <= fifo_q.pop_front();
                inflight = 1'b1;
            end
        end
        ren_prev = r_en;
        d_available <= (fifo_q.size() > 0);

        @(negedge clk);
        chk("word_count", 32'(word_count), 32'(m_wc));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("ren_while_valid", 32'(r_en & out_valid), 32'd0);
        if (prev_valid && !prev_ready && out_valid)
            chk("hold_stable", 32'(out_data), 32'(prev_data));
        if (frame_done) fd_pulses++;
        m_fd = 1'b0;
        if (out_valid && out_ready && reset_n) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                sb_rgb = rgb888(sb_e);
                chk("sb_data", 32'(out_data), 32'(sb_e));
                chk("sb_rgb", 32'({out_r, out_g, out_b}), 32'(sb_rgb));
            end
            inflight = 1'b0;
            m_fd = (m_wc == 3);
            m_wc = m_fd ? 0 : m_wc + 1;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
    end

    initial begin
        int n;
        int base;
        logic seen_ren;
        logic seen_valid;

        // reset state
        repeat (3) tick();
        chk("rst_ren", 32'(r_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        reset_n = 1'b1;

        // single red word: timing and RGB expansion
        push(16'hF800);
        enable = 1'b1;
        n = 0;
        while (!r_en && n < 100) begin tick(); n++; end
        chk("t1_ren_rise", 32'(r_en), 32'd1);
        n = 0;
        while (r_en && n < 20) begin tick(); n++; end
        chk("t1_hold_cycles", 32'(n), 32'd4);
        n = 0;
        while (!r_en && !out_valid && n < 20) begin tick(); n++; end
        chk("t1_gap_plus_capture", 32'(n), 32'd5);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hF800);
        chk("t1_r", 32'(out_r), 32'hFF);
        chk("t1_g", 32'(out_g), 32'h00);
        chk("t1_b", 32'(out_b), 32'h00);
        tick();
        chk("t1_wc", 32'(word_count), 32'd1);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // backpressure with three queued words
        out_ready = 1'b0;
        base = strobes;
        push(16'h1234);
        push(16'hABCD);
        push(16'h5555);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("t2_valid", 32'(out_valid), 32'd1);
        repeat (10) begin
            tick();
            chk("t2_stall_data", 32'(out_data), 32'h1234);
            chk("t2_stall_ren", 32'(r_en), 32'd0);
        end
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin tick(); n++; end
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        repeat (30) tick();
        chk("t2_strobes", 32'(strobes - base), 32'd3);

        // frame wrap with FRAME_WORDS=4
        base = fd_pulses;
        for (int i = 1; i <= 5; i++) push(16'(i));
        n = 0;
        while ((exp_q.size() != 0 || out_valid || r_en) && n < 500) begin tick(); n++; end
        tick();
        chk("t3_drain", 32'(exp_q.size()), 32'd0);
        chk("t3_fd_pulses", 32'(fd_pulses - base), 32'd1);
        chk("t3_wc", 32'(word_count), 32'd1);

        // empty FIFO: no strobes
        seen_ren = 1'b0;
        seen_valid = 1'b0;
        repeat (50) begin
            tick();
            seen_ren |= r_en;
            seen_valid |= out_valid;
        end
        chk("t4_no_ren", 32'(seen_ren), 32'd0);
        chk("t4_no_valid", 32'(seen_valid), 32'd0);

        // reset during the second STROBE_HI cycle
        push(16'h0F0F);
        push(16'h3333);
        n = 0;
        while (!r_en && n < 100) begin tick(); n++; end
        chk("t5_ren_rise", 32'(r_en), 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        chk("t5_ren_drop", 32'(r_en), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_wc", 32'(word_count), 32'd0);
        reset_n = 1'b1;
        chk("t5_first_cycle_ren", 32'(r_en), 32'd0);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin tick(); n++; end
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        chk("t5_wc_after", 32'(word_count), 32'd1);

        // enable dropped in STROBE_LO
        push(16'h07E0);
        push(16'h1111);
        n = 0;
        while (!r_en && n < 100) begin tick(); n++; end
        chk("t6_ren_rise", 32'(r_en), 32'd1);
        n = 0;
        while (r_en && n < 20) begin tick(); n++; end
        chk("t6_ren_fall", 32'(r_en), 32'd0);
        enable = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data", 32'(out_data), 32'h07E0);
        chk("t6_g", 32'(out_g), 32'hFF);
        chk("t6_r", 32'(out_r), 32'h00);
        chk("t6_b", 32'(out_b), 32'h00);
        base = strobes;
        repeat (50) tick();
        chk("t6_no_strobe", 32'(strobes - base), 32'd0);
        chk("t6_valid_clear", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
